// File: rtl/cla_nibble_seq.sv
// Multi-precision adder: one shared 4-bit carry-lookahead slice is stepped across
// NIBBLES nibbles, LSB first. Define CLA_SEQ_OVF_EN to add the signed-overflow output ovf.
module cla_nibble_seq #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   cin,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   cout,
`ifdef CLA_SEQ_OVF_EN
   output logic                   busy,
   output logic                   ovf
`else
   output logic                   busy
`endif
);

   localparam int W    = 4 * NIBBLES;
   localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   logic [W-1:0]      a_sh;
   logic [W-1:0]      b_sh;
   logic              carry;
   logic [IDXW-1:0]   idx;

   logic [3:0]        slice_g;
   logic [3:0]        slice_p;
   logic [4:0]        slice_c;
   logic [3:0]        slice_sum;
   logic              last_pass;

   // Shared 4-bit CLA slice: every carry is a flat function of g, p and the carry register.
   always_comb begin
      slice_g    = a_sh[3:0] & b_sh[3:0];
      slice_p    = a_sh[3:0] ^ b_sh[3:0];
      slice_c[0] = carry;
      slice_c[1] = slice_g[0] | (slice_p[0] & carry);
      slice_c[2] = slice_g[1] | (slice_p[1] & slice_g[0])
                 | (slice_p[1] & slice_p[0] & carry);
      slice_c[3] = slice_g[2] | (slice_p[2] & slice_g[1])
                 | (slice_p[2] & slice_p[1] & slice_g[0])
                 | (slice_p[2] & slice_p[1] & slice_p[0] & carry);
      slice_c[4] = slice_g[3] | (slice_p[3] & slice_g[2])
                 | (slice_p[3] & slice_p[2] & slice_g[1])
                 | (slice_p[3] & slice_p[2] & slice_p[1] & slice_g[0])
                 | (slice_p[3] & slice_p[2] & slice_p[1] & slice_p[0] & carry);
      slice_sum  = slice_p ^ slice_c[3:0];
      last_pass  = (idx == IDXW'(NIBBLES - 1));
   end

   // Control and datapath share one register block; handshake flags are registered with the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         carry     <= 1'b0;
         idx       <= '0;
         a_sh      <= '0;
         b_sh      <= '0;
`ifdef CLA_SEQ_OVF_EN
         ovf       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh     <= a;
                  b_sh     <= b;
                  carry    <= cin;
                  idx      <= '0;
                  state    <= RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               // New nibble enters at the top so nibble k lands at bits 4k+3:4k after the last pass.
               sum   <= (sum >> 4) | (W'(slice_sum) << (W - 4));
               carry <= slice_c[4];
               a_sh  <= a_sh >> 4;
               b_sh  <= b_sh >> 4;
               if (last_pass) begin
                  cout      <= slice_c[4];
                  state     <= DONE;
                  out_valid <= 1'b1;
`ifdef CLA_SEQ_OVF_EN
                  ovf       <= slice_c[3] ^ slice_c[4];
`endif
               end else begin
                  idx <= idx + IDXW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cla_nibble_seq.sv
// Directed bench for cla_nibble_seq: a 16-bit instance driven from a vector table plus
// hand sequences, and a NIBBLES=1 instance for the single-pass corner.
module tb_cla_nibble_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        busy;
   logic        ovf;

   logic        in_valid1;
   logic        in_ready1;
   logic [3:0]  a1;
   logic [3:0]  b1;
   logic        cin1;
   logic        out_valid1;
   logic        out_ready1;
   logic [3:0]  sum1;
   logic        cout1;
   logic        busy1;
   logic        ovf1;

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   cla_nibble_seq #(.NIBBLES(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout),
`ifdef CLA_SEQ_OVF_EN
      .ovf(ovf),
`endif
      .busy(busy)
   );

   cla_nibble_seq #(.NIBBLES(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
      .sum(sum1), .cout(cout1),
`ifdef CLA_SEQ_OVF_EN
      .ovf(ovf1),
`endif
      .busy(busy1)
   );

`ifndef CLA_SEQ_OVF_EN
   assign ovf  = 1'b0;
   assign ovf1 = 1'b0;
`endif

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   vec_t vecs[9];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Accepts one operation on the 16-bit instance, scrambles the inputs, then waits for the result.
   task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                                output int latency);
      int wait_cyc = 0;
      @(negedge clk);
      while (!in_ready && wait_cyc < 50) begin
         @(negedge clk);
         wait_cyc++;
      end
      checkOutput("accept_ready", 32'(in_ready), 32'd1);
      a = va; b = vb; cin = vc; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      latency = 0;
      while (!out_valid && latency < 50) begin
         @(negedge clk);
         latency++;
      end
   endtask

   initial begin
      int lat;
      int prev_ready;
      int accepts;
      int seen;
      int t_first;
      int t_second;

      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[3] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
      vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[6] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[7] = '{16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0};
      vecs[8] = '{16'h0FFF, 16'h7001, 1'b1, 16'h8001, 1'b0, 1'b1};

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
      in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_sum", 32'(sum), 32'd0);
      checkOutput("reset_cout", 32'(cout), 32'd0);
      checkOutput("reset_n1_in_ready", 32'(in_ready1), 32'd1);

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
         checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
         checkOutput($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].sum));
         checkOutput($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
`ifdef CLA_SEQ_OVF_EN
         checkOutput($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
`endif
      end

      // Backpressure: result must hold while the consumer stalls and inputs churn.
      @(negedge clk);
      out_ready = 1'b0;
      applyStimulus(16'h1234, 16'h4321, 1'b0, lat);
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
         checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
         checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
         checkOutput("bp_sum", 32'(sum), 32'h5555);
         checkOutput("bp_cout", 32'(cout), 32'd0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
      checkOutput("bp_release_out_valid", 32'(out_valid), 32'd0);

      // Reset during the second RUN cycle discards the operation.
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("midrun_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midrun_rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("midrun_rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("midrun_rst_busy", 32'(busy), 32'd0);
      checkOutput("midrun_rst_sum", 32'(sum), 32'd0);
      checkOutput("midrun_rst_cout", 32'(cout), 32'd0);
      applyStimulus(16'h0F0F, 16'h0101, 1'b0, lat);
      checkOutput("post_rst_sum", 32'(sum), 32'h1010);
      checkOutput("post_rst_latency", 32'(lat), 32'd4);

      // Back-to-back with in_valid held high: second accept is one IDLE cycle after DONE.
      @(negedge clk);
      while (!in_ready) @(negedge clk);
      a = 16'h0001; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
      prev_ready = int'(in_ready);
      accepts = 0; seen = 0; t_first = -1; t_second = -1;
      for (int cyc = 1; cyc <= 30 && seen < 2; cyc++) begin
         @(negedge clk);
         if (prev_ready != 0 && in_valid) begin
            accepts++;
            if (accepts == 1) begin
               a = 16'h8000; b = 16'h8000;
            end else begin
               in_valid = 1'b0;
            end
         end
         if (out_valid) begin
            seen++;
            if (seen == 1) begin
               t_first = cyc;
               checkOutput("b2b_first_sum", 32'(sum), 32'h0002);
               checkOutput("b2b_first_cout", 32'(cout), 32'd0);
            end else begin
               t_second = cyc;
               checkOutput("b2b_second_sum", 32'(sum), 32'h0000);
               checkOutput("b2b_second_cout", 32'(cout), 32'd1);
            end
         end
         prev_ready = int'(in_ready);
      end
      in_valid = 1'b0;
      checkOutput("b2b_results_seen", 32'(seen), 32'd2);
      checkOutput("b2b_spacing", 32'(t_second - t_first), 32'd6);

      // Single-nibble instance: RUN lasts exactly one cycle.
      @(negedge clk);
      a1 = 4'h9; b1 = 4'h8; cin1 = 1'b0; in_valid1 = 1'b1;
      @(negedge clk);
      in_valid1 = 1'b0; a1 = 4'h0; b1 = 4'h0;
      checkOutput("n1_run_out_valid", 32'(out_valid1), 32'd0);
      @(negedge clk);
      checkOutput("n1_out_valid", 32'(out_valid1), 32'd1);
      checkOutput("n1_sum", 32'(sum1), 32'h1);
      checkOutput("n1_cout", 32'(cout1), 32'd1);
`ifdef CLA_SEQ_OVF_EN
      checkOutput("n1_ovf", 32'(ovf1), 32'd1);
`endif
      @(negedge clk);
      checkOutput("n1_idle_in_ready", 32'(in_ready1), 32'd1);
      a1 = 4'hF; b1 = 4'h0; cin1 = 1'b1; in_valid1 = 1'b1;
      @(negedge clk);
      in_valid1 = 1'b0;
      @(negedge clk);
      checkOutput("n1b_out_valid", 32'(out_valid1), 32'd1);
      checkOutput("n1b_sum", 32'(sum1), 32'h0);
      checkOutput("n1b_cout", 32'(cout1), 32'd1);
`ifdef CLA_SEQ_OVF_EN
      checkOutput("n1b_ovf", 32'(ovf1), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
